// File: rtl/uart_pkg.sv
// Shared state, error-code and header constants for the UART RX frame path.
package uart_pkg;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LEN     = 3'd1;
    localparam logic [2:0] PAYLOAD = 3'd2;
    localparam logic [2:0] CSUM    = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    localparam logic [7:0] HDR_DEFAULT = 8'hAA;

endpackage

// File: rtl/frame_buf.sv
// Payload register file: one synchronous write port, one asynchronous read port.
module frame_buf #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 5
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame parser: header/len/payload/checksum, buffered payload stream.
// Define RX_FRAME_STATS_EN to add the good_cnt/bad_cnt frame statistics.
module uart_rx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned MAX_LEN     = 16,
    parameter logic [7:0]  HDR_BYTE    = HDR_DEFAULT,
    parameter int unsigned TIMEOUT_CYC = 500000
) (
    input  logic        sysclk,
    input  logic        rst_n,
    output logic        rx_en_sig,
    input  logic        rx_done_sig,
    input  logic [7:0]  rx_data,
    output logic [7:0]  pld_data,
    output logic        pld_valid,
    input  logic        pld_ready,
    output logic        pld_last,
    output logic        frame_err,
`ifdef RX_FRAME_STATS_EN
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt,
`endif
    output logic [1:0]  err_code
);

    localparam int unsigned IW = $clog2(MAX_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC);
    localparam logic [7:0]    MAX8     = 8'(MAX_LEN);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] widx_q, widx_d;
    logic [IW-1:0] rd_q, rd_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          en_q;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;

    logic       accept;
    logic       in_frame;
    logic       last_rd;
    logic       hs;
    logic       we;
    logic [7:0] buf_rd;

    assign accept   = rx_done_sig & en_q;
    assign in_frame = (state_q == LEN) | (state_q == PAYLOAD) | (state_q == CSUM);
    assign last_rd  = (rd_q == len_q - IW'(1));
    assign hs       = pld_valid & pld_ready;
    assign we       = (state_q == PAYLOAD) & accept;

    assign rx_en_sig = en_q;
    assign pld_valid = (state_q == DRAIN);
    assign pld_last  = pld_valid & last_rd;
    assign pld_data  = pld_valid ? buf_rd : 8'h00;
    assign frame_err = err_q;
    assign err_code  = code_q;

    frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (IW)
    ) u_buf (
        .clk_i   (sysclk),
        .we_i    (we),
        .waddr_i (widx_q),
        .wdata_i (rx_data),
        .raddr_i (rd_q),
        .rdata_o (buf_rd)
    );

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        rd_d    = rd_q;
        csum_d  = csum_q;
        tmo_d   = '0;
        err_d   = 1'b0;
        code_d  = code_q;

        if (in_frame && !accept) begin
            tmo_d = tmo_q + TW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (accept && rx_data == HDR_BYTE) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (accept) begin
                    if (rx_data == 8'h00 || rx_data > MAX8) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = IDLE;
                    end else begin
                        len_d   = IW'(rx_data);
                        csum_d  = rx_data;
                        widx_d  = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    widx_d = widx_q + IW'(1);
                    csum_d = csum_q + rx_data;
                    if (widx_q == len_q - IW'(1)) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (accept) begin
                    if (rx_data == csum_q) begin
                        rd_d    = '0;
                        state_d = DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (hs) begin
                    rd_d = rd_q + IW'(1);
                    if (last_rd) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // An arriving byte beats an expiring counter.
        if (in_frame && !accept && tmo_q == TMO_LAST) begin
            err_d   = 1'b1;
            code_d  = ERR_TMO;
            tmo_d   = '0;
            state_d = IDLE;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            widx_q  <= '0;
            rd_q    <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            rd_q    <= rd_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            en_q    <= (state_d != DRAIN);
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

`ifdef RX_FRAME_STATS_EN
    logic [15:0] good_q;
    logic [15:0] bad_q;

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            good_q <= '0;
            bad_q  <= '0;
        end else begin
            if (state_d == DRAIN && state_q != DRAIN && good_q != 16'hFFFF) begin
                good_q <= good_q + 16'd1;
            end
            if (err_d && bad_q != 16'hFFFF) begin
                bad_q <= bad_q + 16'd1;
            end
        end
    end

    assign good_cnt = good_q;
    assign bad_cnt  = bad_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl with a payload scoreboard queue.
module tb_uart_rx_frame_ctrl;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 20;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic       sysclk      = 1'b0;
    logic       rst_n       = 1'b0;
    logic       rx_done_sig = 1'b0;
    logic [7:0] rx_data     = 8'h00;
    logic       pld_ready   = 1'b1;
    logic       rx_en_sig;
    logic [7:0] pld_data;
    logic       pld_valid;
    logic       pld_last;
    logic       frame_err;
    logic [1:0] err_code;
`ifdef RX_FRAME_STATS_EN
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;
`endif

    int   checks     = 0;
    int   errors     = 0;
    int   err_pulses = 0;
    exp_t sb_q[$];

    logic       stall_v = 1'b0;
    logic [7:0] stall_d = 8'h00;
    logic       stall_l = 1'b0;

    uart_rx_frame_ctrl #(
        .MAX_LEN     (MAX_LEN),
        .HDR_BYTE    (8'hAA),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .sysclk      (sysclk),
        .rst_n       (rst_n),
        .rx_en_sig   (rx_en_sig),
        .rx_done_sig (rx_done_sig),
        .rx_data     (rx_data),
        .pld_data    (pld_data),
        .pld_valid   (pld_valid),
        .pld_ready   (pld_ready),
        .pld_last    (pld_last),
        .frame_err   (frame_err),
`ifdef RX_FRAME_STATS_EN
        .good_cnt    (good_cnt),
        .bad_cnt     (bad_cnt),
`endif
        .err_code    (err_code)
    );

    always #5 sysclk = ~sysclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data     = b;
        rx_done_sig = 1'b1;
        @(posedge sysclk);
        #1;
        rx_done_sig = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input logic l);
        exp_t e;
        e.d = b;
        e.l = l;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string tag, input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sysclk);
            if (pld_valid !== 1'b1) break;
            n++;
        end
        @(posedge sysclk);
        #1;
        chk({tag, "_beats"}, n, exp_n);
        chk({tag, "_sb_left"}, sb_q.size(), 0);
        chk({tag, "_en_back"}, rx_en_sig, 1);
    endtask

    always @(negedge sysclk) begin
        exp_t e;
        if (frame_err === 1'b1) err_pulses++;
        if (pld_valid === 1'b1) begin
            chk("en_low_in_drain", rx_en_sig, 0);
            if (stall_v) begin
                chk("stall_data", pld_data, stall_d);
                chk("stall_last", pld_last, stall_l);
            end
        end
        stall_v = (pld_valid === 1'b1) && !pld_ready;
        stall_d = pld_data;
        stall_l = pld_last;
        if (pld_valid === 1'b1 && pld_ready) begin
            checks++;
            assert (sb_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_unexpected observed=%0h expected=none", pld_data);
            end
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_data", pld_data, e.d);
                chk("sb_last", pld_last, e.l);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int early;
        logic [7:0] cs;

        // reset state
        repeat (2) @(posedge sysclk);
        #1;
        chk("rst_en", rx_en_sig, 0);
        chk("rst_valid", pld_valid, 0);
        chk("rst_data", pld_data, 0);
        chk("rst_last", pld_last, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_code", err_code, 0);
        rst_n = 1'b1;
        @(posedge sysclk);
        #1;
        chk("idle_en", rx_en_sig, 1);

        // good frame, continuous ready
        base = err_pulses;
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b1);
        send(8'hAA); send(8'h03); send(8'h11);
        send(8'h22); send(8'h33); send(8'h69);
        chk("t1_lat_valid", pld_valid, 1);
        chk("t1_en_drain", rx_en_sig, 0);
        chk("t1_first", pld_data, 8'h11);
        drain("t1", 3);
        chk("t1_no_err", err_pulses, base);

        // checksum error then good frame
        base = err_pulses;
        send(8'hAA); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
        chk("t2_err", frame_err, 1);
        chk("t2_code", err_code, 2);
        chk("t2_valid", pld_valid, 0);
        @(posedge sysclk);
        #1;
        chk("t2_err_width", frame_err, 0);
        chk("t2_valid2", pld_valid, 0);
        push(8'h05, 1'b1);
        send(8'hAA); send(8'h01); send(8'h05); send(8'h06);
        drain("t2", 1);
        chk("t2_pulses", err_pulses, base + 1);

        // length above MAX_LEN
        base = err_pulses;
        send(8'hAA); send(8'h11);
        chk("t3_err", frame_err, 1);
        chk("t3_code", err_code, 1);
        repeat (2) @(posedge sysclk);
        #1;
        chk("t3_pulses", err_pulses, base + 1);

        // inter-byte timeout
        base = err_pulses;
        early = 0;
        send(8'hAA); send(8'h02); send(8'h01);
        repeat (TMO - 1) begin
            @(posedge sysclk);
            #1;
            if (frame_err === 1'b1) early++;
        end
        chk("t4_early", early, 0);
        @(posedge sysclk);
        #1;
        chk("t4_tmo_err", frame_err, 1);
        chk("t4_tmo_code", err_code, 3);
        @(posedge sysclk);
        #1;
        // byte lands on the very edge the counter would expire
        push(8'h01, 1'b0);
        push(8'h02, 1'b1);
        send(8'hAA); send(8'h02); send(8'h01);
        repeat (TMO - 1) @(posedge sysclk);
        #1;
        send(8'h02);
        chk("t4_collide", frame_err, 0);
        send(8'h05);
        chk("t4_valid", pld_valid, 1);
        drain("t4", 2);
        chk("t4_pulses", err_pulses, base + 1);

        // junk byte ignored, zero length
        base = err_pulses;
        send(8'h55); send(8'hAA); send(8'h00);
        chk("t5_err", frame_err, 1);
        chk("t5_code", err_code, 1);
        repeat (2) @(posedge sysclk);
        #1;
        chk("t5_pulses", err_pulses, base + 1);

        // full MAX_LEN frame
        base = err_pulses;
        cs = 8'(MAX_LEN);
        send(8'hAA);
        send(8'(MAX_LEN));
        for (int i = 0; i < MAX_LEN; i++) begin
            logic [7:0] b;
            b = 8'(i * 37 + 3);
            cs = cs + b;
            push(b, (i == MAX_LEN - 1));
            send(b);
        end
        send(cs);
        drain("t6", MAX_LEN);
        chk("t6_no_err", err_pulses, base);

        // stalled drain with a stray rx_done
        push(8'h7F, 1'b0);
        push(8'h80, 1'b1);
        send(8'hAA); send(8'h02); send(8'h7F); send(8'h80);
        pld_ready = 1'b0;
        send(8'h01);
        rx_done_sig = 1'b1;
        rx_data     = 8'hAA;
        chk("t7_valid", pld_valid, 1);
        chk("t7_d0", pld_data, 8'h7F);
        chk("t7_l0", pld_last, 0);
        @(posedge sysclk);
        #1;
        rx_done_sig = 1'b0;
        pld_ready   = 1'b1;
        chk("t7_d1", pld_data, 8'h7F);
        @(posedge sysclk);
        #1;
        pld_ready = 1'b0;
        chk("t7_d2", pld_data, 8'h80);
        chk("t7_l2", pld_last, 1);
        @(posedge sysclk);
        #1;
        chk("t7_d3", pld_data, 8'h80);
        @(posedge sysclk);
        #1;
        pld_ready = 1'b1;
        @(posedge sysclk);
        #1;
        chk("t7_done_valid", pld_valid, 0);
        chk("t7_done_en", rx_en_sig, 1);
        chk("t7_sb_left", sb_q.size(), 0);

        // reset in the middle of a payload
        base = err_pulses;
        send(8'hAA); send(8'h04); send(8'h01);
        rst_n = 1'b0;
        @(posedge sysclk);
        #1;
        rst_n = 1'b1;
        chk("t8_rst_en", rx_en_sig, 0);
        chk("t8_rst_err", frame_err, 0);
        chk("t8_rst_code", err_code, 0);
        @(posedge sysclk);
        #1;
        chk("t8_en", rx_en_sig, 1);
        push(8'hFF, 1'b1);
        send(8'hAA); send(8'h01); send(8'hFF); send(8'h00);
        drain("t8", 1);
        repeat (2) @(posedge sysclk);
        #1;
        chk("t8_no_err", err_pulses, base);
`ifdef RX_FRAME_STATS_EN
        chk("t8_good_cnt", good_cnt, 1);
        chk("t8_bad_cnt", bad_cnt, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sequences the UART receive path: gates its enable, collects received bytes and parses them into framed packets.
- Frame format: header 0xAA, length byte N, N payload bytes, checksum byte.
- Payload goes to an internal buffer and is released on a valid/ready stream only after the checksum passes.
- Sits between the UART receiver and the command/application logic.

Parameters:
- MAX_LEN, 16, maximum payload bytes per frame (1..255); sets buffer depth.
- HDR_BYTE, 8'hAA, frame start byte.
- TIMEOUT_CYC, 500000, sysclk cycles allowed between bytes inside a frame (10 ms at 50 MHz).

Ports:
- sysclk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- rx_en_sig  out  1  enable to the UART receiver; 1 means it may accept bytes.
- rx_done_sig  in  1  single-cycle pulse: byte available on rx_data.
- rx_data  in  8  received byte; valid only when rx_done_sig=1.
- pld_data  out  8  payload byte output.
- pld_valid  out  1  pld_data valid.
- pld_ready  in  1  consumer accepts a byte when valid&ready.
- pld_last  out  1  marks the final payload byte of the frame.
- frame_err  out  1  one-cycle pulse when a frame is discarded.
- err_code  out  2  1=bad length, 2=checksum, 3=timeout; held until the next error; 0 after reset.

Behaviour:
- Synchronous reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - rx_en_sig=0 on the reset cycle, then 1 in IDLE.
  - pld_valid=0, pld_last=0, pld_data=0, frame_err=0, err_code=0.
  - Byte counter, checksum accumulator and timeout counter are cleared.
  - Reset mid-frame or mid-drain drops all buffered data with no error pulse.
- Bytes are consumed only on cycles with rx_done_sig=1 and rx_en_sig=1. rx_done_sig is ignored in DRAIN.
- IDLE:
  - rx_en_sig=1.
  - A byte equal to HDR_BYTE moves to LEN; any other byte is ignored and stays in IDLE.
  - The timeout counter does not run.
- LEN:
  - N=0 or N>MAX_LEN: frame_err pulse, err_code=1, go to IDLE.
  - Otherwise: store N, set csum=N, clear the write index, go to PAYLOAD.
- PAYLOAD:
  - Each byte is written to buf[idx], idx increments, csum=csum+byte (mod 256).
  - After the Nth byte, go to CSUM.
- CSUM:
  - Byte == csum: go to DRAIN with read index 0.
  - Otherwise: frame_err pulse, err_code=2, go to IDLE.
- Timeout:
  - In LEN, PAYLOAD and CSUM the counter counts sysclk cycles and resets to 0 on every accepted byte.
  - Reaching TIMEOUT_CYC-1 gives a frame_err pulse, err_code=3, go to IDLE.
  - If a byte arrives on the same cycle the counter expires, the byte wins; no timeout.
- DRAIN:
  - rx_en_sig=0, giving back-pressure to the UART receiver.
  - pld_valid=1 with pld_data=buf[rd].
  - pld_last=1 when rd==N-1.
  - On valid&ready, rd increments. After the last handshake: pld_valid=0 on the next cycle, return to IDLE, rx_en_sig=1.
  - pld_data and pld_last hold stable while valid&!ready.
- Latency:
  - A checksum byte accepted at cycle t gives pld_valid=1 at t+1.
  - Each handshake advances one byte per cycle, so back-to-back transfers are allowed.
- frame_err is exactly one cycle wide. It never fires in the same cycle as pld_valid rising.
- Widths:
  - Indices are $clog2(MAX_LEN+1) bits.
  - csum is 8 bits and wraps.
  - The timeout counter is $clog2(TIMEOUT_CYC) bits.

Optional Feature:
- Macro: RX_FRAME_STATS_EN.
- When defined, the block adds outputs good_cnt[15:0] and bad_cnt[15:0], both reset to 0.
  - good_cnt increments on entry to DRAIN.
  - bad_cnt increments on each frame_err pulse.
  - Both saturate at 16'hFFFF and do not wrap.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - The state enum: IDLE, LEN, PAYLOAD, CSUM, DRAIN.
  - The err_code constants: ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2, ERR_TMO=3.
  - The default HDR_BYTE.
- One natural sub-module, frame_buf: MAX_LEN x 8 register file with one write port and one async read port.
- The FSM, checksum and timeout logic stay in the top block.

Test Plan:
- Reset, then frame AA 03 11 22 33 69 with pld_ready=1 -> pld stream 11,22,33 on consecutive cycles; pld_last on 33; rx_en_sig=0 during DRAIN; no frame_err.
- Frame AA 02 10 20 00 -> frame_err pulse, err_code=2, no pld_valid, back in IDLE; a following good frame AA 01 05 06 delivers 05.
- Bytes 55 AA 00 -> 55 ignored; frame_err with err_code=1; and AA 11 (MAX_LEN=16) also gives err_code=1.
- AA 02 01, then silence for TIMEOUT_CYC cycles (use TIMEOUT_CYC=20) -> frame_err at cycle 20 after the last byte, err_code=3. A byte at exactly cycle 19 resets the counter instead.
- Good frame AA 02 7F 80 01 with pld_ready toggling 0,1,0,0,1 -> 7F then 80 delivered, data stable while stalled, and an rx_done_sig pulse injected during DRAIN is ignored.
- rst_n=0 for one cycle mid-PAYLOAD, then frame AA 01 FF 00 -> no frame_err from the aborted frame; FF delivered. With RX_FRAME_STATS_EN defined: good_cnt=1, bad_cnt=0.
